// File: rtl/axis_packetizer.sv
// axis_packetizer
//   Collects valid sample words into a single PKT_LEN-deep buffer and emits
//   them as one AXI-Stream packet. A packet closes when the buffer fills or
//   when flush is asserted. While a packet drains, incoming words are dropped
//   and counted.
//
// Ports
//   clock, reset_n     single rising-edge clock, async active-low reset
//   data_in, valid     sample word and its qualifier
//   flush              close the current partial packet and send it
//   ovf_clr            clear overflow and drop_count
//   TCLK               clock passthrough for the stream interface
//   TDATA/TVALID/TLAST AXI-Stream master outputs; TREADY is the downstream ready
//   busy               high while a packet is draining
//   overflow           sticky flag, a word was dropped
//   drop_count         saturating count of dropped words
//
// state | meaning
// FILL  | accepting words into the buffer
// SEND  | draining the buffer onto the stream; input words are dropped
module axis_packetizer #(
   parameter int DATA_WIDTH = 32,
   parameter int PKT_LEN    = 8
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  valid,
   input  logic                  flush,
   input  logic                  ovf_clr,
   input  logic                  TREADY,
   output logic                  TCLK,
   output logic [DATA_WIDTH-1:0] TDATA,
   output logic                  TVALID,
   output logic                  TLAST,
   output logic                  busy,
   output logic                  overflow,
   output logic [15:0]           drop_count
);

   localparam int CW = $clog2(PKT_LEN + 1);
   localparam int AW = $clog2(PKT_LEN);

   typedef enum logic {FILL = 1'b0, SEND = 1'b1} state_t;

   state_t                state, state_nxt;
   logic [DATA_WIDTH-1:0] mem [PKT_LEN];
   logic [CW-1:0]         wr_cnt, rd_idx, pkt_len;
   logic [CW-1:0]         fill_len;
   logic                  full_write, do_flush, go_send;
   logic                  is_last, last_xfer, drop;

   assign TCLK = clock;

   // Length the packet would have if it closed this cycle; a word written
   // in the flush cycle belongs to the packet.
   assign fill_len   = wr_cnt + CW'(valid);
   assign full_write = (state == FILL) && valid && (wr_cnt == CW'(PKT_LEN - 1));
   assign do_flush   = (state == FILL) && flush && (fill_len != '0);
   assign go_send    = full_write || do_flush;
   assign is_last    = (rd_idx == pkt_len - CW'(1));
   assign last_xfer  = (state == SEND) && TREADY && is_last;
   assign drop       = (state == SEND) && valid;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= FILL;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FILL:    if (go_send)   state_nxt = SEND;
         SEND:    if (last_xfer) state_nxt = FILL;
         default: state_nxt = FILL;
      endcase
   end

   // Outputs depend only on registered state, so reset clears them at once.
   always_comb begin
      TVALID = 1'b0;
      TDATA  = '0;
      TLAST  = 1'b0;
      busy   = 1'b0;
      if (state == SEND) begin
         TVALID = 1'b1;
         TDATA  = mem[rd_idx[AW-1:0]];
         TLAST  = is_last;
         busy   = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_cnt  <= '0;
         rd_idx  <= '0;
         pkt_len <= '0;
      end else if (state == FILL) begin
         if (valid)   wr_cnt  <= wr_cnt + CW'(1);
         if (go_send) pkt_len <= fill_len;
      end else if (TREADY) begin
         if (is_last) begin
            wr_cnt <= '0;
            rd_idx <= '0;
         end else begin
            rd_idx <= rd_idx + CW'(1);
         end
      end
   end

   // Buffer storage carries no reset; stale contents are never read because
   // rd_idx only walks entries written for the current packet.
   always_ff @(posedge clock) begin
      if ((state == FILL) && valid) mem[wr_cnt[AW-1:0]] <= data_in;
   end

   // A clear in the same cycle as a drop leaves that drop counted.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         overflow   <= 1'b0;
         drop_count <= '0;
      end else if (ovf_clr) begin
         overflow   <= drop;
         drop_count <= drop ? 16'd1 : 16'd0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_axis_packetizer.sv
module tb_axis_packetizer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] din;
   logic        vld, fl, clr, rdy;
   logic        tclk, tvalid, tlast, bsy, ovf;
   logic [31:0] tdata;
   logic [15:0] dcnt;

   logic [15:0] s_din;
   logic        s_vld, s_fl, s_clr, s_rdy;
   logic        s_tclk, s_tvalid, s_tlast, s_bsy, s_ovf;
   logic [15:0] s_tdata;
   logic [15:0] s_dcnt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   axis_packetizer dut (
      .clock(clk), .reset_n(rst_n), .data_in(din), .valid(vld), .flush(fl),
      .ovf_clr(clr), .TREADY(rdy), .TCLK(tclk), .TDATA(tdata), .TVALID(tvalid),
      .TLAST(tlast), .busy(bsy), .overflow(ovf), .drop_count(dcnt)
   );

   axis_packetizer #(.DATA_WIDTH(16), .PKT_LEN(2)) dut_s (
      .clock(clk), .reset_n(rst_n), .data_in(s_din), .valid(s_vld), .flush(s_fl),
      .ovf_clr(s_clr), .TREADY(s_rdy), .TCLK(s_tclk), .TDATA(s_tdata), .TVALID(s_tvalid),
      .TLAST(s_tlast), .busy(s_bsy), .overflow(s_ovf), .drop_count(s_dcnt)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input logic [31:0] first, input int n);
      for (int i = 0; i < n; i++) begin
         vld = 1'b1;
         din = first + 32'(i);
         tick();
         if (i < n - 1) check_val("fill_no_tvalid", 64'(tvalid), 64'd0);
      end
      vld = 1'b0;
      din = '0;
   endtask

   task automatic drain(input logic [31:0] first, input int n);
      for (int k = 0; k < n; k++) begin
         check_val("drain_tvalid", 64'(tvalid), 64'd1);
         check_val("drain_tdata",  64'(tdata),  64'(first + 32'(k)));
         check_val("drain_tlast",  64'(tlast),  64'(k == n - 1));
         check_val("drain_busy",   64'(bsy),    64'd1);
         tick();
      end
      check_val("post_tvalid", 64'(tvalid), 64'd0);
      check_val("post_busy",   64'(bsy),    64'd0);
   endtask

   initial begin
      int e, nlast, c;
      logic [3:0] pat;

      rst_n = 1'b0; din = '0; vld = 0; fl = 0; clr = 0; rdy = 1'b1;
      s_din = '0; s_vld = 0; s_fl = 0; s_clr = 0; s_rdy = 1'b1;
      #3;
      check_val("rst_tvalid", 64'(tvalid), 64'd0);
      check_val("rst_tdata",  64'(tdata),  64'd0);
      check_val("rst_tlast",  64'(tlast),  64'd0);
      check_val("rst_busy",   64'(bsy),    64'd0);
      check_val("rst_ovf",    64'(ovf),    64'd0);
      check_val("rst_dcnt",   64'(dcnt),   64'd0);
      #9 rst_n = 1'b1;
      tick();
      check_val("tclk_high", 64'(tclk), 64'd1);

      // full packet, TREADY always high
      fill(32'h1, 8);
      drain(32'h1, 8);

      // flush with the third word
      vld = 1; din = 32'hA; tick();
      din = 32'hB; tick();
      din = 32'hC; fl = 1; tick();
      vld = 0; fl = 0; din = '0;
      drain(32'hA, 3);

      // flush with nothing stored
      fl = 1; tick(); fl = 0;
      check_val("empty_flush_tvalid", 64'(tvalid), 64'd0);
      tick();
      check_val("empty_flush_tvalid2", 64'(tvalid), 64'd0);

      // back-pressure pattern 1,0,0,1
      pat = 4'b1001;
      fill(32'h11, 8);
      e = 0; nlast = 0; c = 0;
      while (e < 8 && c < 40) begin
         rdy = pat[c % 4];
         check_val("bp_tvalid", 64'(tvalid), 64'd1);
         check_val("bp_tdata",  64'(tdata),  64'(32'h11 + 32'(e)));
         check_val("bp_tlast",  64'(tlast),  64'(e == 7));
         if (rdy && tlast) nlast++;
         tick();
         if (rdy) e++;
         c++;
      end
      rdy = 1'b1;
      check_val("bp_words", 64'(e), 64'd8);
      check_val("bp_nlast", 64'(nlast), 64'd1);
      check_val("bp_after_tvalid", 64'(tvalid), 64'd0);

      // drops during SEND
      rdy = 1'b0;
      fill(32'h21, 8);
      for (int i = 0; i < 5; i++) begin
         vld = 1; din = 32'hDEAD0 + 32'(i); tick();
      end
      vld = 0; din = '0;
      check_val("drop_ovf",  64'(ovf),  64'd1);
      check_val("drop_dcnt", 64'(dcnt), 64'd5);
      vld = 1; clr = 1; din = 32'hBAD; tick();
      vld = 0; clr = 0; din = '0;
      check_val("clr_drop_ovf",  64'(ovf),  64'd1);
      check_val("clr_drop_dcnt", 64'(dcnt), 64'd1);
      rdy = 1'b1;
      drain(32'h21, 8);
      clr = 1; tick(); clr = 0;
      check_val("clr_ovf",  64'(ovf),  64'd0);
      check_val("clr_dcnt", 64'(dcnt), 64'd0);

      // reset on the fourth word of SEND
      fill(32'h31, 8);
      tick(); tick(); tick();
      check_val("pre_rst_tdata", 64'(tdata), 64'h34);
      #1 rst_n = 1'b0;
      #1;
      check_val("async_rst_tvalid", 64'(tvalid), 64'd0);
      check_val("async_rst_tdata",  64'(tdata),  64'd0);
      check_val("async_rst_busy",   64'(bsy),    64'd0);
      #3 rst_n = 1'b1;
      tick();
      check_val("post_rst_tvalid", 64'(tvalid), 64'd0);
      fill(32'h41, 8);
      drain(32'h41, 8);

      // PKT_LEN=2, DATA_WIDTH=16
      s_vld = 1; s_din = 16'h1234; tick();
      check_val("s_fill_tvalid", 64'(s_tvalid), 64'd0);
      s_din = 16'hBEEF; tick();
      s_vld = 0; s_din = '0;
      check_val("s_w0_tvalid", 64'(s_tvalid), 64'd1);
      check_val("s_w0_tdata",  64'(s_tdata),  64'h1234);
      check_val("s_w0_tlast",  64'(s_tlast),  64'd0);
      tick();
      check_val("s_w1_tdata",  64'(s_tdata),  64'hBEEF);
      check_val("s_w1_tlast",  64'(s_tlast),  64'd1);
      check_val("s_w1_busy",   64'(s_bsy),    64'd1);
      tick();
      check_val("s_end_tvalid", 64'(s_tvalid), 64'd0);
      s_vld = 1; s_din = 16'h5555; tick();
      s_vld = 0; s_din = '0;
      check_val("s_one_wait", 64'(s_tvalid), 64'd0);
      s_fl = 1; tick(); s_fl = 0;
      check_val("s_one_tvalid", 64'(s_tvalid), 64'd1);
      check_val("s_one_tdata",  64'(s_tdata),  64'h5555);
      check_val("s_one_tlast",  64'(s_tlast),  64'd1);
      tick();
      check_val("s_one_end",  64'(s_tvalid), 64'd0);
      check_val("s_ovf",      64'(s_ovf),    64'd0);
      check_val("s_dcnt",     64'(s_dcnt),   64'd0);
      check_val("s_tclk",     64'(s_tclk),   64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
